// File: rtl/booth_divider_seq.sv
// Sequential non-restoring radix-2 divider: 2N-bit dividend / N-bit divisor.
// Operands arrive byte-serially on sw under Go; result is {remainder, quotient}.
module booth_divider_seq #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   sw,
   input  logic           Go,
   output logic [2*N-1:0] result,
   output logic [2:0]     state,
   output logic           done,
   output logic           err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LDH    = 3'd1,
      LDL    = 3'd2,
      CHECK  = 3'd3,
      ITER   = 3'd4,
      FIX    = 3'd5,
      DONE   = 3'd6,
      UNUSED = 3'd7
   } st_t;

   localparam int CW = $clog2(N + 1);

   st_t            state_q, state_d;
   logic [N-1:0]   div_q, div_d;
   logic [N-1:0]   dhi_q, dhi_d;
   logic [N-1:0]   dlo_q, dlo_d;
   logic [N-1:0]   q_q, q_d;
   logic [N+1:0]   p_q, p_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] res_q, res_d;
   logic           err_q, err_d;
   logic           done_q, done_d;

   logic [N+1:0]   d_ext;
   logic [N+1:0]   p_sh;
   logic [N+1:0]   p_it;
   logic [N+1:0]   p_fix;

   // P carries two guard bits so that 2P +/- D never wraps.
   assign d_ext = {2'b00, div_q};
   assign p_sh  = {p_q[N:0], q_q[N-1]};
   assign p_it  = p_q[N+1] ? (p_sh + d_ext) : (p_sh - d_ext);
   assign p_fix = p_q[N+1] ? (p_q + d_ext) : p_q;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      dhi_d   = dhi_q;
      dlo_d   = dlo_q;
      q_d     = q_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (Go) begin
               div_d   = sw;
               state_d = LDH;
            end
         end
         LDH: begin
            if (Go) begin
               dhi_d   = sw;
               state_d = LDL;
            end
         end
         LDL: begin
            if (Go) begin
               dlo_d   = sw;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (div_q == '0 || dhi_q >= div_q) begin
               err_d   = 1'b1;
               res_d   = '1;
               state_d = DONE;
            end else begin
               p_d     = {2'b00, dhi_q};
               q_d     = dlo_q;
               cnt_d   = CW'(N);
               state_d = ITER;
            end
         end
         ITER: begin
            p_d   = p_it;
            q_d   = {q_q[N-2:0], ~p_it[N+1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = FIX;
         end
         FIX: begin
            p_d     = p_fix;
            res_d   = {p_fix[N-1:0], q_q};
            err_d   = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            if (Go) begin
               div_d   = sw;
               state_d = LDH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign done_d = (state_d == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         dhi_q   <= '0;
         dlo_q   <= '0;
         q_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         dhi_q   <= dhi_d;
         dlo_q   <= dlo_d;
         q_q     <= q_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign result = res_q;
   assign state  = state_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule

// File: tb/tb_booth_divider_seq.sv
// Scoreboard bench for booth_divider_seq: directed loads, monitor on done rise.
module tb_booth_divider_seq;

   logic        clk;
   logic        rst;
   logic [7:0]  sw;
   logic        Go;
   logic [15:0] result;
   logic [2:0]  state;
   logic        done;
   logic        err;

   booth_divider_seq #(.N(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .sw     (sw),
      .Go     (Go),
      .result (result),
      .state  (state),
      .done   (done),
      .err    (err)
   );

   typedef struct {
      logic [15:0] res;
      logic        err;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   logic done_prev = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per rising edge of done.
   always @(negedge clk) begin
      exp_t e;
      if (done && !done_prev) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1, expected none");
         end else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("err", 32'(err), 32'(e.err));
            chk("latency_cycle", 32'(cyc), 32'(e.due));
         end
      end
      done_prev = done;
   end

   task automatic go_byte(input logic [7:0] b);
      @(negedge clk);
      sw = b;
      Go = 1'b1;
      @(negedge clk);
      Go = 1'b0;
   endtask

   task automatic load(input logic [7:0] dv, input logic [7:0] hi,
                       input logic [7:0] lo, output int t);
      go_byte(dv);
      go_byte(hi);
      go_byte(lo);
      t = cyc;
   endtask

   task automatic expect_op(input int t, input logic [15:0] r,
                            input logic e);
      exp_t x;
      x.res = r;
      x.err = e;
      x.due = t + (e ? 1 : 10);
      sb.push_back(x);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [7:0] dv, input logic [7:0] hi,
                      input logic [7:0] lo, input logic [15:0] r,
                      input logic e);
      int t;
      load(dv, hi, lo, t);
      expect_op(t, r, e);
      drain();
   endtask

   initial begin
      int t;
      rst = 1'b1;
      Go  = 1'b0;
      sw  = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      rst = 1'b0;

      run(8'd7, 8'h03, 8'hE8, 16'h068E, 1'b0);
      chk("done_held", 32'(done), 32'd1);
      chk("state_done", 32'(state), 32'd6);
      run(8'hFF, 8'hFE, 8'hFF, 16'hFEFF, 1'b0);
      run(8'd0, 8'h12, 8'h34, 16'hFFFF, 1'b1);
      run(8'd8, 8'h08, 8'h00, 16'hFFFF, 1'b1);
      run(8'd2, 8'h00, 8'h05, 16'h0102, 1'b0);

      // Abort mid-ITER with a one-cycle reset.
      load(8'd7, 8'h03, 8'hE8, t);
      repeat (4) @(negedge clk);
      chk("iter4_state", 32'(state), 32'd4);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_err", 32'(err), 32'd0);
      rst = 1'b0;
      run(8'd10, 8'h00, 8'd100, 16'h000A, 1'b0);

      // Go chatter during CHECK/ITER/FIX must not disturb the operation.
      load(8'd7, 8'h03, 8'hE8, t);
      expect_op(t, 16'h068E, 1'b0);
      for (int k = 0; k < 10; k++) begin
         Go = (k % 2 == 0);
         sw = 8'h5A + 8'(k);
         @(negedge clk);
      end
      Go = 1'b0;
      drain();
      chk("chatter_state", 32'(state), 32'd6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/booth_divider_seq.md
Name: booth_divider_seq

Overview:
- Sequential unsigned divider, 2N-bit dividend by N-bit divisor, giving an N-bit quotient and an N-bit remainder.
- Non-restoring, radix-2 algorithm.
- It is the inverse-operation companion to the radix-4 Booth multiplier and sits beside it on the same switch/Go/result board interface.
- Operands are entered byte-serially on sw under Go pulses.
- The result is presented as {remainder, quotient} on the same 16-bit result bus the multiplier uses.

Parameters:
N, 8, operand width. The dividend is 2N bits; the result is 2N bits. Only N=8 is signed off.

Ports:
clk  in  1  clock; all registers update on posedge
rst  in  1  reset, synchronous, active-high
sw  in  N  operand input byte
Go  in  1  single-cycle load/start strobe (debounced upstream)
result  out  2N  {remainder[N-1:0], quotient[N-1:0]}
state  out  3  current FSM state encoding
done  out  1  high while in DONE
err  out  1  high in DONE when the last operation was divide-by-zero or overflow

Behaviour:
- Reset: state=IDLE(0); result=0, done=0, err=0; divisor, dividend and partial-remainder registers all 0.
- Reset asserted in any state, including mid-ITER, aborts the operation and applies the reset values on the next posedge.
- FSM states and encodings:
  - IDLE=0: Go=1 -> divisor<=sw; go to LDH.
  - LDH=1: Go=1 -> dividend_hi<=sw; go to LDL. Otherwise hold.
  - LDL=2: Go=1 -> dividend_lo<=sw; go to CHECK. Otherwise hold.
  - CHECK=3:
    - If divisor==0: err<=1, result<={2N{1}}, go to DONE.
    - Else if dividend_hi>=divisor (quotient overflow): err<=1, result<={2N{1}}, go to DONE.
    - Else: P<={2'b00,dividend_hi} (P is N+2 bits, two's complement), Q<=dividend_lo, cnt<=N, go to ITER.
  - ITER=4: each cycle:
    - Shift {P,Q} left by 1; Q[0] gets 0 temporarily.
    - If the old P>=0, P<=shifted_P−D; else P<=shifted_P+D. D is the divisor zero-extended to N+2 bits.
    - Q[0]<=~P_new[N+1].
    - cnt<=cnt−1. When cnt reaches 1 in this cycle, go to FIX. ITER therefore lasts exactly N cycles.
  - FIX=5: if P<0 then P<=P+D. result<={P_corrected[N-1:0], Q}; err<=0; go to DONE.
  - DONE=6: done=1, result and err held.
    - Go=1 -> divisor<=sw; go to LDH, starting the next operation.
    - done drops on leaving DONE. result and err hold until the next write in CHECK or FIX.
  - 7: unused; recovers to IDLE on the next clock.
- Go is ignored in CHECK, ITER and FIX. No operand register changes during these states.
- Latency: Go accepted in LDL at edge t -> CHECK at t+1, ITER t+2..t+N+1, FIX t+N+2, done=1 from t+N+3. For N=8 that is 11 cycles.
- Error path: CHECK goes directly to DONE, so done=1 two cycles after the LDL Go.
- Width rules:
  - P is N+2 bits so that ±2D does not overflow.
  - All arithmetic is two's complement within P.
  - Quotient correctness is guaranteed only when dividend_hi<divisor; CHECK enforces this.
- sw is sampled only on the posedge where Go=1 in IDLE, LDH, LDL or DONE.
- A multi-cycle Go held high advances one load state per cycle. This is a legal but unusual use.
- Invariant for verification: after FIX, 0<=remainder<divisor and Q*divisor+remainder==dividend.

Test Plan:
- Load divisor=7, dividend_hi=0x03, dividend_lo=0xE8 (1000) -> done 11 cycles after the last Go; result=0x068E (r=6, q=142); err=0.
- Load divisor=0xFF, dividend=0xFEFF -> result=0xFEFF (r=254, q=255); err=0.
- Load divisor=0, any dividend -> DONE two cycles after the last Go; err=1; result=0xFFFF.
- Load divisor=8, dividend=0x0800 (hi=8>=8) -> err=1; result=0xFFFF. Then Go with divisor=2 and dividend=0x0005 -> err=0; result=0x0102.
- Apply rst for one cycle during the 4th ITER cycle -> next edge: state=0, result=0, done=0, err=0. A subsequent full load of 100/10 gives result=0x000A.
- Toggle Go during CHECK/ITER/FIX -> no effect: operand registers unchanged and the result matches the undisturbed run.
